// File: rtl/softmax_norm_64_if.sv
// Handshake and data bundle between the softmax adder tree and the normaliser.
// master drives vectors and out_ready; slave is the normaliser.
interface softmax_norm_64_if #(
   parameter int LANES = 64,
   parameter int DW    = 16
);
   logic                valid_in;
   logic                in_ready;
   logic [1:0]          length_mode;
   logic [DW-1:0]       sum_64_0;
   logic [DW-1:0]       sum_32_0;
   logic [DW-1:0]       sum_32_1;
   logic [DW-1:0]       sum_16_0;
   logic [DW-1:0]       sum_16_1;
   logic [DW-1:0]       sum_16_2;
   logic [DW-1:0]       sum_16_3;
   logic [LANES*DW-1:0] data_flat;
   logic                valid_out;
   logic                out_ready;
   logic [LANES*DW-1:0] out_flat;
   logic [1:0]          length_mode_out;
   logic                div_zero;

   modport master (
      output valid_in, length_mode, data_flat, out_ready,
      output sum_64_0, sum_32_0, sum_32_1,
      output sum_16_0, sum_16_1, sum_16_2, sum_16_3,
      input  in_ready, valid_out, out_flat, length_mode_out, div_zero
   );

   modport slave (
      input  valid_in, length_mode, data_flat, out_ready,
      input  sum_64_0, sum_32_0, sum_32_1,
      input  sum_16_0, sum_16_1, sum_16_2, sum_16_3,
      output in_ready, valid_out, out_flat, length_mode_out, div_zero
   );
endinterface

// File: rtl/softmax_norm_64.sv
// Softmax normaliser: per-segment reciprocal by restoring division, then lane scaling.
// Define SOFTMAX_NORM_ROUND_EN for round-half-up scaling instead of truncation.
module softmax_norm_64 #(
   parameter int LANES     = 64,
   parameter int DW        = 16,
   parameter int FRAC      = 8,
   parameter int MUL_LANES = 16
) (
   input logic               clk,
   input logic               rst,
   input logic               en,
   softmax_norm_64_if.slave  bus
);
   localparam int NCH = LANES / MUL_LANES;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int SW  = $clog2(2*FRAC+1);
   localparam int PW  = 2*DW + 1;

   typedef enum logic [1:0] {IDLE, RECIP, MUL, OUT} state_t;

   state_t              state;
   logic [1:0]          mode_q;
   logic [DW-1:0]       sum_q [4];
   logic [DW-1:0]       recip [4];
   logic [LANES*DW-1:0] lane_q;
   logic [1:0]          seg;
   logic [SW-1:0]       step;
   logic [DW:0]         rem;
   logic [DW:0]         quo;
   logic [CW-1:0]       chunk;

   logic                m10, m01;
   logic [1:0]          seg_last;
   logic [DW-1:0]       cur_sum;
   logic [DW:0]         dsum, rem_sh, rem_n, quo_n;
   logic                geq;
   logic [DW-1:0]       recip_n;
   logic [LANES*DW-1:0] lane_n;

   assign m10      = (mode_q == 2'b10);
   assign m01      = (mode_q == 2'b01);
   assign seg_last = m10 ? 2'd3 : (m01 ? 2'd1 : 2'd0);

   // one quotient bit per cycle; dividend 2^(2*FRAC) has its only 1 at step 0
   always_comb begin
      cur_sum = sum_q[seg];
      dsum    = {1'b0, cur_sum};
      rem_sh  = (rem << 1) | (DW+1)'(step == '0);
      geq     = (rem_sh >= dsum);
      rem_n   = geq ? (rem_sh - dsum) : rem_sh;
      quo_n   = (quo << 1) | (DW+1)'(geq);
      if (cur_sum == '0)
         recip_n = '0;
      else if (quo_n[DW])
         recip_n = '1;
      else
         recip_n = quo_n[DW-1:0];
   end

   always_comb begin
      lane_n = lane_q;
      for (int j = 0; j < MUL_LANES; j++) begin : scale
         int            idx;
         logic [1:0]    sg;
         logic [PW-1:0] p;
         logic [PW-1:0] sh;
         idx = int'(chunk) * MUL_LANES + j;
         if (m10)
            sg = 2'(idx / (LANES/4));
         else if (m01)
            sg = 2'(idx / (LANES/2));
         else
            sg = 2'd0;
         p = PW'((2*DW)'(lane_q[idx*DW +: DW]) * (2*DW)'(recip[sg]));
`ifdef SOFTMAX_NORM_ROUND_EN
         p = p + PW'(1 << (FRAC-1));
`endif
         sh = p >> FRAC;
         lane_n[idx*DW +: DW] = (|sh[PW-1:DW]) ? '1 : sh[DW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         bus.in_ready        <= 1'b1;
         bus.valid_out       <= 1'b0;
         bus.out_flat        <= '0;
         bus.length_mode_out <= 2'b00;
         bus.div_zero        <= 1'b0;
         mode_q              <= 2'b00;
         lane_q              <= '0;
         seg                 <= '0;
         step                <= '0;
         rem                 <= '0;
         quo                 <= '0;
         chunk               <= '0;
         for (int k = 0; k < 4; k++) begin
            sum_q[k] <= '0;
            recip[k] <= '0;
         end
      end else if (en) begin
         unique case (state)
            IDLE: begin
               if (bus.valid_in) begin
                  mode_q       <= bus.length_mode;
                  lane_q       <= bus.data_flat;
                  bus.div_zero <= 1'b0;
                  bus.in_ready <= 1'b0;
                  seg          <= '0;
                  step         <= '0;
                  rem          <= '0;
                  quo          <= '0;
                  state        <= RECIP;
                  unique case (bus.length_mode)
                     2'b01: begin
                        sum_q[0] <= bus.sum_32_0;
                        sum_q[1] <= bus.sum_32_1;
                        sum_q[2] <= '0;
                        sum_q[3] <= '0;
                     end
                     2'b10: begin
                        sum_q[0] <= bus.sum_16_0;
                        sum_q[1] <= bus.sum_16_1;
                        sum_q[2] <= bus.sum_16_2;
                        sum_q[3] <= bus.sum_16_3;
                     end
                     default: begin
                        sum_q[0] <= bus.sum_64_0;
                        sum_q[1] <= '0;
                        sum_q[2] <= '0;
                        sum_q[3] <= '0;
                     end
                  endcase
               end
            end
            RECIP: begin
               if (step == SW'(2*FRAC)) begin
                  recip[seg] <= recip_n;
                  if (cur_sum == '0)
                     bus.div_zero <= 1'b1;
                  step <= '0;
                  rem  <= '0;
                  quo  <= '0;
                  if (seg == seg_last) begin
                     chunk <= '0;
                     state <= MUL;
                  end else begin
                     seg <= seg + 2'd1;
                  end
               end else begin
                  step <= step + SW'(1);
                  rem  <= rem_n;
                  quo  <= quo_n;
               end
            end
            MUL: begin
               lane_q <= lane_n;
               if (chunk == CW'(NCH-1)) begin
                  bus.out_flat        <= lane_n;
                  bus.length_mode_out <= mode_q;
                  bus.valid_out       <= 1'b1;
                  state               <= OUT;
               end else begin
                  chunk <= chunk + CW'(1);
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  bus.valid_out <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_softmax_norm_64.sv
// Self-checking bench for softmax_norm_64: directed table, corner sequences, random vs model.
// Honors SOFTMAX_NORM_ROUND_EN to pick the rounding reference.
module tb_softmax_norm_64;
   localparam int L  = 64;
   localparam int DW = 16;
   localparam int VW = L*DW;

`ifdef SOFTMAX_NORM_ROUND_EN
   localparam logic [15:0] E_RND = 16'h0002;
`else
   localparam logic [15:0] E_RND = 16'h0001;
`endif

   typedef struct packed {
      logic [1:0]  mode;
      logic [15:0] ev, od;
      logic [15:0] s64, s320, s321, s160, s161, s162, s163;
      logic [15:0] e0, e63;
      logic        dz;
      logic [7:0]  lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;

   int checks = 0;
   int errors = 0;
   logic [VW-1:0] last_out;
   int            last_lat;

   softmax_norm_64_if #(.LANES(L), .DW(DW)) bus ();

   softmax_norm_64 dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic chk_vec(input string nm, input logic [VW-1:0] got,
                          input logic [VW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         for (int i = 0; i < L; i++)
            if (got[i*DW +: DW] !== exp[i*DW +: DW]) begin
               $display("FAIL %s lane %0d got=%0h exp=%0h", nm, i,
                        got[i*DW +: DW], exp[i*DW +: DW]);
               break;
            end
      end
   endtask

   function automatic void model(input logic [1:0] m, input logic [VW-1:0] d,
                                 input logic [15:0] s[7], output logic [VW-1:0] o,
                                 output bit dz, output int lat);
      int     nseg;
      longint r [4];
      longint sv;
      longint p;
      nseg = (m == 2'b10) ? 4 : ((m == 2'b01) ? 2 : 1);
      dz = 0;
      o  = '0;
      for (int k = 0; k < 4; k++) r[k] = 0;
      for (int k = 0; k < nseg; k++) begin
         sv = (nseg == 1) ? longint'(s[0]) :
              (nseg == 2) ? longint'(s[1+k]) : longint'(s[3+k]);
         if (sv == 0) begin
            r[k] = 0;
            dz = 1;
         end else begin
            r[k] = 65536 / sv;
            if (r[k] > 65535) r[k] = 65535;
         end
      end
      for (int i = 0; i < L; i++) begin
         p = longint'(d[i*DW +: DW]) * r[i / (L/nseg)];
`ifdef SOFTMAX_NORM_ROUND_EN
         p = p + 128;
`endif
         p = p >> 8;
         if (p > 65535) p = 65535;
         o[i*DW +: DW] = 16'(p);
      end
      lat = nseg*17 + L/16;
   endfunction

   task automatic send(input logic [1:0] m, input logic [VW-1:0] d,
                       input logic [15:0] s[7]);
      bus.length_mode = m;
      bus.data_flat   = d;
      bus.sum_64_0    = s[0];
      bus.sum_32_0    = s[1];
      bus.sum_32_1    = s[2];
      bus.sum_16_0    = s[3];
      bus.sum_16_1    = s[4];
      bus.sum_16_2    = s[5];
      bus.sum_16_3    = s[6];
      bus.valid_in    = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_in    = 1'b0;
      // scramble inputs so only the captured copy can produce the result
      bus.data_flat   = ~d;
      bus.sum_64_0    = ~s[0];
      bus.sum_32_0    = ~s[1];
      bus.sum_32_1    = ~s[2];
      bus.sum_16_0    = ~s[3];
      bus.sum_16_1    = ~s[4];
      bus.sum_16_2    = ~s[5];
      bus.sum_16_3    = ~s[6];
      bus.length_mode = ~m;
   endtask

   task automatic wait_out(input int limit, output int lat);
      lat = 0;
      while (bus.valid_out !== 1'b1 && lat < limit) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (bus.valid_out !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_out timeout got=%0d exp<%0d", lat, limit);
      end
   endtask

   task automatic run_vec(input logic [1:0] m, input logic [VW-1:0] d,
                          input logic [15:0] s[7], input string tag);
      logic [VW-1:0] eo;
      bit            edz;
      int            elat;
      int            lat;
      model(m, d, s, eo, edz, elat);
      send(m, d, s);
      wait_out(200, lat);
      chk({tag, "_lat"}, lat, elat);
      chk_vec({tag, "_data"}, bus.out_flat, eo);
      chk({tag, "_dz"}, bus.div_zero, edz);
      chk({tag, "_lmo"}, bus.length_mode_out, m);
      last_out = bus.out_flat;
      last_lat = lat;
      @(posedge clk);
      #1;
      chk({tag, "_xfer_rdy"}, {bus.valid_out, bus.in_ready}, 2'b01);
   endtask

   vec_t          tbl [7];
   logic [15:0]   s [7];
   logic [VW-1:0] d;
   logic [VW-1:0] snap;
   logic [VW-1:0] eo;
   bit            edz;
   int            elat;
   int            lat;
   int            cnt;
   bit            stable;

   initial begin
      bus.valid_in    = 1'b0;
      bus.out_ready   = 1'b1;
      bus.length_mode = 2'b00;
      bus.data_flat   = '0;
      bus.sum_64_0    = '0;
      bus.sum_32_0    = '0;
      bus.sum_32_1    = '0;
      bus.sum_16_0    = '0;
      bus.sum_16_1    = '0;
      bus.sum_16_2    = '0;
      bus.sum_16_3    = '0;

      tbl[0] = '{2'b00, 16'h0100, 16'h0100, 16'h4000, 16'h1111, 16'h2222,
                 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h0004, 16'h0004, 1'b0, 8'd21};
      tbl[1] = '{2'b10, 16'h0080, 16'h0080, 16'h1234, 16'h0000, 16'h0000,
                 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0010, 16'h0010, 1'b0, 8'd72};
      tbl[2] = '{2'b01, 16'h0100, 16'h0100, 16'h0000, 16'h2000, 16'h0000,
                 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0008, 16'h0000, 1'b1, 8'd38};
      tbl[3] = '{2'b00, 16'h0100, 16'h0200, 16'h0001, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 8'd21};
      tbl[4] = '{2'b00, 16'h0003, 16'h0003, 16'h0200, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, E_RND, E_RND, 1'b0, 8'd21};
      tbl[5] = '{2'b11, 16'h0100, 16'h0100, 16'h0300, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0055, 16'h0055, 1'b0, 8'd21};
      tbl[6] = '{2'b10, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
                 16'h0100, 16'h0000, 16'h4000, 16'hFFFF, 16'h0100, 16'h0001, 1'b1, 8'd72};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", {bus.valid_out, bus.in_ready, bus.length_mode_out, bus.div_zero},
          5'b01000);
      chk_vec("rst_out", bus.out_flat, '0);
      rst = 1'b0;

      for (int t = 0; t < 7; t++) begin
         for (int i = 0; i < L; i++)
            d[i*DW +: DW] = (i % 2 == 1) ? tbl[t].od : tbl[t].ev;
         s = '{tbl[t].s64, tbl[t].s320, tbl[t].s321, tbl[t].s160,
               tbl[t].s161, tbl[t].s162, tbl[t].s163};
         run_vec(tbl[t].mode, d, s, $sformatf("tbl%0d", t));
         chk($sformatf("tbl%0d_lane0", t), last_out[0 +: DW], tbl[t].e0);
         chk($sformatf("tbl%0d_lane63", t), last_out[63*DW +: DW], tbl[t].e63);
         chk($sformatf("tbl%0d_tlat", t), last_lat, tbl[t].lat);
         chk($sformatf("tbl%0d_tdz", t), bus.div_zero, tbl[t].dz);
      end

      // backpressure with ignored valid_in pulses
      for (int i = 0; i < L; i++) d[i*DW +: DW] = 16'h0100;
      s = '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      model(2'b00, d, s, eo, edz, elat);
      bus.out_ready = 1'b0;
      send(2'b00, d, s);
      wait_out(200, lat);
      chk("bp_lat", lat, 21);
      snap = bus.out_flat;
      chk_vec("bp_data", snap, eo);
      stable = 1;
      for (int k = 0; k < 10; k++) begin
         bus.valid_in  = (k % 2 == 0);
         bus.data_flat = {32{$urandom()}};
         @(posedge clk);
         #1;
         if (!(bus.valid_out === 1'b1 && bus.in_ready === 1'b0 &&
               bus.out_flat === snap && bus.div_zero === 1'b0))
            stable = 0;
      end
      bus.valid_in  = 1'b0;
      chk("bp_stable", stable, 1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release", {bus.valid_out, bus.in_ready}, 2'b01);
      chk_vec("bp_hold_last", bus.out_flat, snap);
      cnt = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (bus.valid_out) cnt++;
      end
      chk("bp_no_queue", cnt, 0);

      // reset mid-RECIP aborts the vector
      s = '{16'h0, 16'h0, 16'h0, 16'h0800, 16'h0800, 16'h0800, 16'h0800};
      send(2'b10, d, s);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid", {bus.valid_out, bus.in_ready}, 2'b01);
      chk_vec("rst_mid_out", bus.out_flat, '0);
      rst = 1'b0;
      cnt = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (bus.valid_out) cnt++;
      end
      chk("rst_no_out", cnt, 0);

      // enable held low for 5 cycles during MUL
      s = '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      model(2'b00, d, s, eo, edz, elat);
      send(2'b00, d, s);
      repeat (18) @(posedge clk);
      #1;
      en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      en = 1'b1;
      wait_out(200, lat);
      chk("en_lat", 23 + lat, 26);
      chk_vec("en_data", bus.out_flat, eo);
      @(posedge clk);
      #1;
      chk("en_xfer", {bus.valid_out, bus.in_ready}, 2'b01);

      // random vectors against the model
      for (int n = 0; n < 40; n++) begin
         logic [1:0] m;
         m = 2'($urandom_range(0, 3));
         for (int i = 0; i < L; i++)
            d[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 65535))
                                                       : 16'($urandom_range(0, 1023));
         for (int k = 0; k < 7; k++) begin
            int kind;
            kind = $urandom_range(0, 9);
            s[k] = (kind == 0) ? 16'h0000 :
                   (kind == 1) ? 16'($urandom_range(1, 4)) :
                                 16'($urandom_range(1, 65535));
         end
         run_vec(m, d, s, $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
